// File: rtl/fifo_read_ctrl.sv
// Read-domain controller for the asynchronous FIFO (clk2 side).
// Owns the binary/Gray read pointers, brings the Gray write pointer across
// with a two-flop synchroniser, and derives Empty and a conservative
// occupancy count. A small FSM sequences either consumer-driven single
// reads or fixed-length bursts. It drives the memory read address and
// strobe directly.
module fifo_read_ctrl #(
    parameter int DEPTH     = 512,
    parameter int PTR_WIDTH = 9
) (
    input  logic                 clk2,
    input  logic                 rst,
    input  logic                 Read,
    input  logic                 burst_req,
    input  logic [PTR_WIDTH:0]   burst_len,
    input  logic [PTR_WIDTH:0]   wr_ptr_gray,
    output logic [PTR_WIDTH:0]   rd_ptr_gray,
    output logic [PTR_WIDTH-1:0] rd_addr,
    output logic                 mem_rd_en,
    output logic                 Empty,
    output logic                 Data_valid,
    output logic                 Underflow,
    output logic [PTR_WIDTH:0]   rd_count,
    output logic                 burst_busy,
    output logic                 burst_done
);

    // The address field must cover the memory exactly, otherwise the wrap
    // bit would not mark a full lap of the buffer.
    if (DEPTH != (2 ** PTR_WIDTH)) begin : g_depth_check
        $error("fifo_read_ctrl: DEPTH must equal 2**PTR_WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [PTR_WIDTH:0] LP_ONE = (PTR_WIDTH+1)'(1);

    // Registered state
    state_t             r_state;
    logic [PTR_WIDTH:0] r_cnt;
    logic [PTR_WIDTH:0] r_rd_bin;
    logic [PTR_WIDTH:0] r_rd_gray;
    logic [PTR_WIDTH:0] r_wq1;
    logic [PTR_WIDTH:0] r_wq2;
    logic               r_empty;
    logic               r_data_valid;
    logic               r_underflow;
    logic               r_burst_done;

    // Combinational helpers
    logic               w_burst_start;
    logic               w_req;
    logic               w_rd_fire;
    logic [PTR_WIDTH:0] w_rd_bin_next;
    logic [PTR_WIDTH:0] w_rd_gray_next;
    logic [PTR_WIDTH:0] w_wq2_bin;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Request selection, read accept and next-pointer arithmetic.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_burst_start = 1'b0;
        w_req         = 1'b0;
        w_burst_start = (r_state == ST_IDLE) && burst_req && (burst_len != '0);
        case (r_state)
            // A burst request in the same cycle takes priority; the Read is dropped.
            ST_IDLE:  w_req = Read && !w_burst_start;
            ST_BURST: w_req = 1'b1;
            default:  w_req = 1'b0;
        endcase
        w_rd_fire      = w_req && !r_empty;
        w_rd_bin_next  = r_rd_bin + {{PTR_WIDTH{1'b0}}, w_rd_fire};
        w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);
        w_wq2_bin      = gray2bin(r_wq2);
    end

    // Two-flop synchroniser bringing the write pointer into clk2.
    always_ff @(posedge clk2 or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_wq1 <= '0;
            r_wq2 <= '0;
        end else begin
            r_wq1 <= wr_ptr_gray;
            r_wq2 <= r_wq1;
        end
    end

    // Read pointers, Empty flag and the one-cycle-late data-valid strobe.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            r_rd_bin     <= '0;
            r_rd_gray    <= '0;
            r_empty      <= 1'b1;
            r_data_valid <= 1'b0;
        end else begin
            r_rd_bin     <= w_rd_bin_next;
            r_rd_gray    <= w_rd_gray_next;
            // Full-width compare: equal wrap bits and addresses mean nothing left.
            r_empty      <= (w_rd_gray_next == r_wq2);
            r_data_valid <= w_rd_fire;
        end
    end

    // Burst sequencer with registered Underflow and burst_done pulses.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_underflow  <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            r_underflow  <= (r_state == ST_IDLE) && Read && r_empty && !w_burst_start;
            r_burst_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_burst_start) begin
                        r_cnt   <= burst_len;
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    // Stalls silently while Empty; each accepted word counts down.
                    if (w_rd_fire) begin
                        r_cnt <= r_cnt - LP_ONE;
                        if (r_cnt == LP_ONE) begin
                            r_state      <= ST_DONE;
                            r_burst_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_ptr_gray = r_rd_gray;
    assign rd_addr     = r_rd_bin[PTR_WIDTH-1:0];
    assign mem_rd_en   = w_rd_fire;
    assign Empty       = r_empty;
    assign Data_valid  = r_data_valid;
    assign Underflow   = r_underflow;
    // The synchronised write pointer is at least two cycles stale, so this
    // count can only under-report what is really in the FIFO.
    assign rd_count    = w_wq2_bin - r_rd_bin;
    assign burst_busy  = (r_state == ST_BURST);
    assign burst_done  = r_burst_done;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Testbench for fifo_read_ctrl: a driver applies directed and random
// stimulus and feeds a cycle-level reference model, which pushes expected
// per-cycle state and expected output events into queues; an independent
// monitor on the falling edge pops and compares.
module tb_fifo_read_ctrl;

    localparam int PW   = 9;
    localparam int MOD  = 1024;   // pointer range including the wrap bit
    localparam int AMSK = 511;    // address mask

    logic          clk2;
    logic          rst;
    logic          Read;
    logic          burst_req;
    logic [PW:0]   burst_len;
    logic [PW:0]   wr_ptr_gray;
    logic [PW:0]   rd_ptr_gray;
    logic [PW-1:0] rd_addr;
    logic          mem_rd_en;
    logic          Empty;
    logic          Data_valid;
    logic          Underflow;
    logic [PW:0]   rd_count;
    logic          burst_busy;
    logic          burst_done;

    fifo_read_ctrl #(.DEPTH(512), .PTR_WIDTH(PW)) dut (
        .clk2        (clk2),
        .rst         (rst),
        .Read        (Read),
        .burst_req   (burst_req),
        .burst_len   (burst_len),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_ptr_gray (rd_ptr_gray),
        .rd_addr     (rd_addr),
        .mem_rd_en   (mem_rd_en),
        .Empty       (Empty),
        .Data_valid  (Data_valid),
        .Underflow   (Underflow),
        .rd_count    (rd_count),
        .burst_busy  (burst_busy),
        .burst_done  (burst_done)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    // Event kinds: 0 read fire, 1 data valid, 2 underflow, 3 burst done
    typedef struct {
        int kind;
        int cyc;
        int addr;
    } ev_t;

    typedef struct {
        int cyc;
        int empty;
        int gray;
        int count;
        int avail;
        int busy;
    } st_t;

    ev_t   q_ev[$];
    st_t   q_st[$];
    string ev_name [4] = '{"mem_rd_en", "Data_valid", "Underflow", "burst_done"};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: words read so far, the writer's pointer as driven in
    // the last three cycles, words left in the current burst, DONE cycle flag.
    int m_reads;
    int m_hist [3];
    int m_left;
    bit m_in_done;
    int w_cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PW:0] gray10(input int v);
        logic [PW:0] b;
        b = v[PW:0];
        return b ^ (b >> 1);
    endfunction

    function automatic void push_ev(input int kind, input int c, input int a);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.addr = a;
        q_ev.push_back(e);
    endfunction

    function automatic void model_reset();
        m_reads   = 0;
        foreach (m_hist[i]) m_hist[i] = 0;
        m_left    = 0;
        m_in_done = 0;
        q_ev.delete();
    endfunction

    // The reader only learns of writes after synchronisation: Empty this cycle
    // reflects the writer pointer from three cycles back, rd_count from two.
    function automatic bit push_state(input int w);
        st_t s;
        bit  empty;
        empty   = ((m_reads % MOD) == (m_hist[2] % MOD));
        s.cyc   = cyc;
        s.empty = int'(empty);
        s.gray  = int'(gray10(m_reads));
        s.count = (m_hist[1] - m_reads) % MOD;
        s.avail = w - m_reads;
        s.busy  = (m_left > 0) ? 1 : 0;
        q_st.push_back(s);
        return empty;
    endfunction

    function automatic void model_cycle(input bit rd, input bit br, input int bl, input int w);
        bit empty;
        bit fire;
        bit was_done;
        empty     = push_state(w);
        fire      = 1'b0;
        was_done  = m_in_done;
        m_in_done = 1'b0;
        if (!was_done) begin
            if (m_left > 0) begin
                if (!empty) begin
                    fire = 1'b1;
                    m_left--;
                    if (m_left == 0) begin
                        push_ev(3, cyc + 1, 0);
                        m_in_done = 1'b1;
                    end
                end
            end else if (br && ((bl % MOD) != 0)) begin
                m_left = bl % MOD;
            end else if (rd) begin
                if (empty) push_ev(2, cyc + 1, 0);
                else       fire = 1'b1;
            end
        end
        if (fire) begin
            push_ev(0, cyc, m_reads & AMSK);
            push_ev(1, cyc + 1, m_reads & AMSK);
            m_reads++;
        end
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = w;
    endfunction

    // One clk2 cycle of stimulus, applied just after the rising edge.
    task automatic step(input bit r, input bit rd, input bit br, input int bl, input int w);
        @(posedge clk2);
        #1;
        rst         = r;
        Read        = rd;
        burst_req   = br;
        burst_len   = bl[PW:0];
        wr_ptr_gray = gray10(w);
        if (r) begin
            model_reset();
            void'(push_state(0));
        end else begin
            model_cycle(rd, br, bl, w);
        end
        cyc++;
    endtask

    // Monitor: compares state and output events on the falling edge.
    st_t mst;
    initial begin
        forever begin
            @(negedge clk2);
            if (q_st.size() > 0) begin
                mst = q_st.pop_front();
                check("Empty",       Empty,       mst.empty);
                check("rd_ptr_gray", rd_ptr_gray, mst.gray);
                check("rd_count",    rd_count,    mst.count);
                check("rd_count_le_avail", (int'(rd_count) <= mst.avail) ? 1 : 0, 1);
                check("burst_busy",  burst_busy,  mst.busy);
                for (int k = 0; k < 4; k++) begin
                    int   idx;
                    logic act;
                    idx = -1;
                    case (k)
                        0:       act = mem_rd_en;
                        1:       act = Data_valid;
                        2:       act = Underflow;
                        default: act = burst_done;
                    endcase
                    foreach (q_ev[i]) begin
                        if (idx < 0 && q_ev[i].kind == k && q_ev[i].cyc == mst.cyc) idx = i;
                    end
                    check(ev_name[k], act, (idx >= 0) ? 1 : 0);
                    if (idx >= 0) begin
                        if (k == 0 && act === 1'b1) check("rd_addr", rd_addr, q_ev[idx].addr);
                        q_ev.delete(idx);
                    end
                end
            end
        end
    end

    // Time limit so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        Read        = 1'b0;
        burst_req   = 1'b0;
        burst_len   = '0;
        wr_ptr_gray = '0;
        model_reset();
        w_cur = 0;

        // Reset state
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

        // Three words appear; reads start once Empty falls.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3);

        // Read while empty: one Underflow pulse, pointer still.
        step(0, 1, 0, 0, 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3);

        // Stream 520 words from a fresh reset across the address wrap.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 700 && m_reads < 520; i++) begin
            w_cur = (m_reads + 8 < 520) ? m_reads + 8 : 520;
            step(0, (m_reads < 520), 0, 0, w_cur);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, w_cur);

        // Burst of 4 with 2 words available; Read in the same cycle is dropped.
        w_cur = m_reads + 2;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, w_cur);
        step(0, 1, 1, 4, w_cur);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, w_cur);
        w_cur = w_cur + 2;
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, w_cur);

        // Reset in the middle of a stalled burst, then ordinary reads.
        w_cur = m_reads + 2;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, w_cur);
        step(0, 0, 1, 4, w_cur);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, w_cur);
        w_cur = 0;
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0);
        w_cur = 2;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, w_cur);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, w_cur);

        // Random traffic: writer never more than DEPTH ahead.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                w_cur = 0;
                step(1, 0, 0, 0, 0);
            end else begin
                int lim;
                lim   = m_reads + 512;
                w_cur = w_cur + int'($urandom_range(0, 2));
                if (w_cur > lim) w_cur = lim;
                step(0, ($urandom_range(0, 9) < 6), ($urandom_range(0, 14) == 0),
                     int'($urandom_range(0, 12)), w_cur);
            end
        end

        // Drain: make data plentiful so any open burst completes.
        w_cur = m_reads + 512;
        for (int i = 0; i < 24; i++) step(0, 0, 0, 0, w_cur);

        @(negedge clk2);
        #1;
        check("pending_events", q_ev.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
